// File: rtl/md_unit.sv
// md_unit: MIPS multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU run as fixed-latency multi-cycle operations on latched
// operands. MTHI/MTLO write HI/LO in a single cycle.
// Optional feature macro MD_CANCEL_EN adds a 'cancel' input that flushes an
// in-flight operation without touching HI/LO and blocks a concurrent start.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
`ifdef MD_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MULT_LAST = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LAST  = 4'(DIV_CYCLES - 1);

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic signed [31:0]  a_q, a_d;
  logic signed [31:0]  b_q, b_d;
  logic [31:0]         hi_q, hi_d;
  logic [31:0]         lo_q, lo_d;
  logic [63:0]         res;
  logic                cancel_w;

`ifdef MD_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  // Signed divide via magnitudes so the most-negative / -1 case wraps
  // cleanly instead of overflowing. Returns {remainder, quotient}.
  function automatic logic [63:0] div_signed(input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    ua = a[31] ? (~a + 32'd1) : a;
    ub = b[31] ? (~b + 32'd1) : b;
    q  = ua / ub;
    r  = ua % ub;
    if (a[31] ^ b[31]) q = ~q + 32'd1;
    if (a[31])         r = ~r + 32'd1;
    return {r, q};
  endfunction

  // Unsigned divide with the divide-by-zero convention. Returns {rem, quot}.
  function automatic logic [63:0] div_unsigned(input logic [31:0] a,
                                               input logic [31:0] b);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  // {hi, lo} result of the latched operation.
  function automatic logic [63:0] md_result(input logic [1:0]         o,
                                            input logic signed [31:0] a,
                                            input logic signed [31:0] b);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    pu = {32'd0, a} * {32'd0, b};
    case (o)
      2'd0:    return ps;
      2'd1:    return pu;
      2'd2:    return div_signed(a, b);
      default: return div_unsigned(a, b);
    endcase
  endfunction

  assign res  = md_result(op_q, a_q, b_q);
  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Next-state logic: accept in IDLE, count down in RUN, commit at zero.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start && !cancel_w) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              a_d     = src_a;
              b_d     = src_b;
              op_d    = op[1:0];
              cnt_d   = op[1] ? DIV_LAST : MULT_LAST;
              state_d = RUN;
              busy_d  = 1'b1;
            end
            3'd4:    hi_d = src_a;
            3'd5:    lo_d = src_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cancel_w) begin
          // Flush: results are dropped, HI/LO untouched.
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          hi_d    = res[63:32];
          lo_d    = res[31:0];
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, operand latches and HI/LO registers with async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= 4'd0;
      op_q    <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule
